// File: rtl/moving_avg_ctrl.sv
// Sequences samples into the moving-average datapath: load strobe, LAT-cycle wait, then present the average.
// Handshake to out_valid takes LAT+2 cycles; in_ready is only high in IDLE, so a stalled output backpressures upstream.
module moving_avg_ctrl #(
  parameter int DW       = 8,
  parameter int WIN_LOG2 = 2,
  parameter int LAT      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic signed [DW-1:0] dp_num,
  output logic                 dp_load,
  output logic                 dp_clr,
  input  logic signed [DW-1:0] dp_avg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_avg,
  output logic [WIN_LOG2:0]    fill
);

  localparam int              WIN_I  = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2:0] WIN  = WIN_I[WIN_LOG2:0];
  localparam logic [3:0]      LAT_M1 = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_PRESENT} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [WIN_LOG2:0]     r_fill;
  logic signed [DW-1:0]  r_dp_num;
  logic signed [DW-1:0]  r_out_avg;
  logic                  r_dp_load;
  logic                  r_dp_clr;
  logic                  r_out_valid;
  logic                  r_clr_d;

  // rst gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = rst & ~clear & (r_state == S_IDLE);
  assign dp_num    = r_dp_num;
  assign dp_load   = r_dp_load;
  assign dp_clr    = r_dp_clr;
  assign out_valid = r_out_valid;
  assign out_avg   = r_out_avg;
  assign fill      = r_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fill      <= '0;
      r_dp_num    <= '0;
      r_out_avg   <= '0;
      r_dp_load   <= 1'b0;
      r_dp_clr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_clr_d     <= 1'b0;
    end else begin
      r_dp_load <= 1'b0;
      r_dp_clr  <= 1'b0;
      r_clr_d   <= clear;
      if (clear) begin
        // Flush overrides everything, including an output being taken this cycle.
        r_state     <= S_IDLE;
        r_fill      <= '0;
        r_out_valid <= 1'b0;
        r_dp_clr    <= ~r_clr_d;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_dp_num  <= in_data;
              r_dp_load <= 1'b1;
              r_state   <= S_LOAD;
              if (r_fill != WIN) r_fill <= r_fill + 1'b1;
            end
          end
          S_LOAD: begin
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (r_cnt == 4'd0) begin
              if (r_fill == WIN) begin
                r_out_avg   <= dp_avg;
                r_out_valid <= 1'b1;
                r_state     <= S_PRESENT;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_PRESENT: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Directed bench for moving_avg_ctrl with a behavioural 4-tap averaging datapath of latency 2.
module tb_moving_avg_ctrl;

  logic              clk, rst, clear, in_valid, in_ready, dp_load, dp_clr;
  logic              out_valid, out_ready;
  logic signed [7:0] in_data, dp_num, dp_avg, out_avg;
  logic [2:0]        fill;

  int n_checks = 0;
  int n_fail   = 0;

  moving_avg_ctrl #(.DW(8), .WIN_LOG2(2), .LAT(2)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_num(dp_num), .dp_load(dp_load), .dp_clr(dp_clr), .dp_avg(dp_avg),
    .out_valid(out_valid), .out_ready(out_ready), .out_avg(out_avg),
    .fill(fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath stand-in: window of the last 4 loaded samples, average available 2 cycles after dp_load.
  logic signed [7:0] m_win [4];
  logic signed [7:0] m_p1, m_p2;
  int                m_sum;
  assign m_sum  = int'(m_win[1]) + int'(m_win[2]) + int'(m_win[3]) + int'(dp_num);
  assign dp_avg = m_p2;

  always @(posedge clk or negedge rst) begin
    if (!rst || dp_clr) begin
      for (int i = 0; i < 4; i++) m_win[i] <= '0;
      m_p1 <= '0;
      m_p2 <= '0;
    end else begin
      if (dp_load) begin
        m_win[0] <= m_win[1];
        m_win[1] <= m_win[2];
        m_win[2] <= m_win[3];
        m_win[3] <= dp_num;
        m_p1     <= 8'(m_sum >>> 2);
      end
      m_p2 <= m_p1;
    end
  end

  logic signed [7:0] stream_in  [7];
  logic signed [7:0] stream_out [4];

  task automatic send(input logic signed [7:0] d);
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: sample %0d never accepted (in_ready stayed 0), required acceptance", d);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (fill !== 3'd0)      begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
    n_checks++; if (dp_num !== 8'sd0)   begin n_fail++; $display("FAIL reset_dp_num: got %0d want 0", dp_num); end
    n_checks++; if (out_avg !== 8'sd0)  begin n_fail++; $display("FAIL reset_out_avg: got %0d want 0", out_avg); end
    n_checks++; if ({dp_load, dp_clr} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {dp_load, dp_clr}); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_fill_and_first_avg();
    logic signed [7:0] smp [4];
    int first_ov;
    smp = '{8'sd2, 8'sd1, -8'sd1, 8'sd4};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(smp[i]);
      first_ov = 0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (n == 1) begin
          n_checks++;
          if (fill !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fill, i + 1); end
        end
        if (out_valid && first_ov == 0) begin
          first_ov = n;
          if (i == 3) begin
            n_checks++;
            if (out_avg !== 8'sd1) begin n_fail++; $display("FAIL first_avg: got %0d want 1", out_avg); end
          end
        end
      end
      n_checks++;
      if (first_ov !== ((i == 3) ? 4 : 0)) begin
        n_fail++; $display("FAIL out_valid_timing[%0d]: first out_valid cycle %0d want %0d (0=none)", i, first_ov, (i == 3) ? 4 : 0);
      end
    end
  endtask

  task automatic test_latency_strobes();
    send(8'sd7);
    @(negedge clk);
    n_checks++; if (dp_load !== 1'b1)  begin n_fail++; $display("FAIL lat_dp_load_n1: got %b want 1", dp_load); end
    n_checks++; if (dp_num !== 8'sd7)  begin n_fail++; $display("FAIL lat_dp_num: got %0d want 7", dp_num); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL lat_in_ready_n1: got %b want 0", in_ready); end
    for (int n = 2; n <= 3; n++) begin
      @(negedge clk);
      n_checks++;
      if ({dp_load, in_ready, out_valid} !== 3'b000) begin
        n_fail++; $display("FAIL lat_wait_n%0d: load/in_ready/out_valid got %b want 000", n, {dp_load, in_ready, out_valid});
      end
    end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL lat_present: out_valid/in_ready got %b%b want 10", out_valid, in_ready); end
    n_checks++; if (out_avg !== 8'sd2) begin n_fail++; $display("FAIL lat_avg: got %0d want 2", out_avg); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_back_idle: in_ready/out_valid got %b%b want 10", in_ready, out_valid); end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    out_ready = 1'b0;
    send(8'sd3);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_out_valid: never asserted, want 1"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, dp_load} !== 3'b100 || out_avg !== 8'sd3) begin
        n_fail++; $display("FAIL bp_stall[%0d]: valid/ready/load %b avg %0d want 100 avg 3", c, {out_valid, in_ready, dp_load}, out_avg);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_transfer: out_valid got %b want 1", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: out_valid/in_ready got %b%b want 01", out_valid, in_ready); end
  endtask

  task automatic test_clear_mid_wait();
    int first_ov;
    bit bad = 0;
    send(8'sd5);
    @(negedge clk);
    n_checks++; if (dp_load !== 1'b1) begin n_fail++; $display("FAIL clr_dp_load: got %b want 1", dp_load); end
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    n_checks++; if (dp_clr !== 1'b1)    begin n_fail++; $display("FAIL clr_dp_clr: got %b want 1", dp_clr); end
    n_checks++; if (fill !== 3'd0)      begin n_fail++; $display("FAIL clr_fill: got %0d want 0", fill); end
    n_checks++; if (out_avg !== 8'sd3)  begin n_fail++; $display("FAIL clr_out_avg_held: got %0d want 3", out_avg); end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_idle: in_ready/out_valid got %b%b want 10", in_ready, out_valid); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (out_valid || dp_clr) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL clr_discard: out_valid or dp_clr seen after clear, want none"); end
    for (int i = 0; i < 4; i++) begin
      send(-8'sd8);
      first_ov = 0;
      for (int n = 1; n <= 6; n++) begin
        @(negedge clk);
        if (out_valid && first_ov == 0) begin
          first_ov = n;
          if (i == 3) begin
            n_checks++;
            if (out_avg !== -8'sd8) begin n_fail++; $display("FAIL clr_refill_avg: got %0d want -8", out_avg); end
          end
        end
      end
      n_checks++;
      if (first_ov !== ((i == 3) ? 4 : 0)) begin
        n_fail++; $display("FAIL clr_refill_timing[%0d]: first out_valid %0d want %0d (0=none)", i, first_ov, (i == 3) ? 4 : 0);
      end
    end
  endtask

  task automatic test_clear_hold();
    int pulses = 0;
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_data = 8'sd55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (dp_clr) pulses++;
        n_checks++;
        if (fill !== 3'd0) begin n_fail++; $display("FAIL hold_fill[%0d]: got %0d want 0", i, fill); end
      end
      n_checks++;
      if (in_ready !== 1'b0 || dp_load !== 1'b0) begin n_fail++; $display("FAIL hold_blocked[%0d]: in_ready/dp_load got %b%b want 00", i, in_ready, dp_load); end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL hold_dp_clr_pulses: got %0d want 1", pulses); end
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    out_ready = 1'b0;
    send(8'sd10); send(8'sd20); send(8'sd30); send(8'sd40);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++; if (!seen || out_avg !== 8'sd25) begin n_fail++; $display("FAIL ar_present: seen %b avg %0d want 1 avg 25", seen, out_avg); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL ar_outputs: out_valid/in_ready got %b want 00", {out_valid, in_ready}); end
    n_checks++; if (fill !== 3'd0 || out_avg !== 8'sd0) begin n_fail++; $display("FAIL ar_state: fill %0d avg %0d want 0 0", fill, out_avg); end
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_release: in_ready/out_valid got %b%b want 10", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    int hs = 0, outs = 0, last_c = 0;
    bit take;
    stream_in  = '{8'sd4, 8'sd8, -8'sd4, 8'sd12, 8'sd0, -8'sd16, 8'sd1};
    stream_out = '{8'sd5, 8'sd4, -8'sd2, -8'sd1};
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = stream_in[0];
    for (int c = 0; c < 200 && (hs < 7 || outs < 4); c++) begin
      @(negedge clk);
      take = in_ready;
      if (out_valid && out_ready) begin
        n_checks++;
        if (outs < 4 && out_avg !== stream_out[outs]) begin n_fail++; $display("FAIL stream_avg[%0d]: got %0d want %0d", outs, out_avg, stream_out[outs]); end
        outs++;
      end
      @(posedge clk); #1;
      if (take) begin
        if (hs > 0) begin
          n_checks++;
          // One extra cycle once the previous sample produced an output (its PRESENT cycle).
          if (c - last_c !== ((hs > 3) ? 5 : 4)) begin
            n_fail++; $display("FAIL stream_gap[%0d]: got %0d cycles want %0d", hs, c - last_c, (hs > 3) ? 5 : 4);
          end
        end
        last_c = c;
        hs++;
        if (hs < 7) in_data = stream_in[hs];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (hs !== 7 || outs !== 4) begin n_fail++; $display("FAIL stream_count: accepted %0d outputs %0d want 7 4", hs, outs); end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_fill_and_first_avg();
    test_latency_strobes();
    test_backpressure();
    test_clear_mid_wait();
    test_clear_hold();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
